grad_bram_seq: RTL and testbench

GRAD_BRAM_SEQ -- requirements
Module: grad_bram_seq

---
 rtl/grad_pkg.sv | 24 ++
 rtl/sat_dncnt.sv | 25 ++
 rtl/grad_bram_seq.sv | 156 +++++++++++++++
 tb/tb_grad_bram_seq.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/grad_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the gradient BRAM sequencer and the OCRA1 serialiser.
package grad_pkg;
    localparam int unsigned WORD_W    = 32;
    localparam int unsigned IVL_W     = 16;
    localparam int unsigned GUARD_DEF = 3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAITD,
        ST_HOLD,
        ST_ISSUE,
        ST_DONE
    } state_t;

    // OCRA1 word layout: channel 26:25, broadcast 24, payload 23:0.
    typedef struct packed {
        logic [4:0]  rsvd;
        logic [1:0]  chan;
        logic        bcast;
        logic [23:0] payload;
    } ocra_word_t;
endpackage

// File: rtl/sat_dncnt.sv
`timescale 1ns/1ps
// Loadable down-counter that stops at zero; load wins over decrement.
module sat_dncnt #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    output logic         o_zero_c
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero_c = (r_cnt == '0);
endmodule

// File: rtl/grad_bram_seq.sv
`timescale 1ns/1ps
// Plays gradient words from BRAM to the OCRA1 serialiser with a minimum issue
// interval and a post-broadcast guard window on the serialiser busy flag.
module grad_bram_seq
    import grad_pkg::*;
#(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned GUARD  = GUARD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    input  logic [IVL_W-1:0]  interval_i,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic              bram_en_o,
    input  logic [WORD_W-1:0] bram_data_i,
    output logic [WORD_W-1:0] data_o,
    output logic              valid_o,
    input  logic              busy_i,
    output logic              running_o,
    output logic              done_o,
    output logic              stall_o
);
    localparam int unsigned GUARD_W = 8;
    // HOLD first samples the counter two cycles after the ISSUE that loaded it.
    localparam int unsigned IVL_BIAS = 2;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [ADDR_W-1:0]   r_end_addr;
    logic [IVL_W-1:0]    r_interval;
    logic [IVL_W-1:0]    w_ivl_load;
    ocra_word_t          r_data;
    logic                r_valid;
    logic                r_en;
    logic                r_running;
    logic                r_done;
    logic                r_stall;
    logic                w_start;
    logic                w_ivl_zero;
    logic                w_guard_zero;
    logic                w_bcast;
    logic                w_issue_ok;
    logic                w_issue_now;
    logic                w_stall_set;

    assign w_bcast     = r_data.bcast;
    assign w_issue_now = (r_state == ST_ISSUE);
    assign w_issue_ok  = w_ivl_zero && (!w_bcast || (w_guard_zero && !busy_i));
    assign w_stall_set = (r_state == ST_HOLD) && w_ivl_zero && !w_issue_ok && !stop_i;
    assign w_ivl_load  = (r_interval > IVL_W'(IVL_BIAS)) ? (r_interval - IVL_W'(IVL_BIAS)) : '0;

    sat_dncnt #(.W(IVL_W)) u_ivl_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_issue_now),
        .i_value  (w_ivl_load),
        .o_zero_c (w_ivl_zero)
    );

    sat_dncnt #(.W(GUARD_W)) u_guard_ctr (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_issue_now && w_bcast),
        .i_value  (GUARD_W'(GUARD)),
        .o_zero_c (w_guard_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and playback address; stop overrides every non-idle transition.
    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    w_start     = 1'b1;
                    w_addr_nxt  = '0;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: w_state_nxt = ST_WAITD;
            ST_WAITD: w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (w_issue_ok) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_addr == r_end_addr) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_addr_nxt  = r_addr + ADDR_W'(1);
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (stop_i && (r_state != ST_IDLE)) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr     <= '0;
            r_end_addr <= '0;
            r_interval <= '0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_en       <= 1'b0;
            r_running  <= 1'b0;
            r_done     <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            r_addr    <= w_addr_nxt;
            r_valid   <= (w_state_nxt == ST_ISSUE);
            r_en      <= (w_state_nxt == ST_FETCH);
            r_running <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
            if (w_start) begin
                r_end_addr <= end_addr_i;
                r_interval <= interval_i;
            end
            if (r_state == ST_WAITD) begin
                r_data <= bram_data_i;
            end
            if (w_start) begin
                r_stall <= 1'b0;
            end else if (w_stall_set) begin
                r_stall <= 1'b1;
            end
        end
    end

    assign bram_addr_o = r_addr;
    assign bram_en_o   = r_en;
    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign running_o   = r_running;
    assign done_o      = r_done;
    assign stall_o     = r_stall;
endmodule

// File: tb/tb_grad_bram_seq.sv
`timescale 1ns/1ps
// Bench for grad_bram_seq: scoreboarded issue data plus issue-timing checks,
// and a second narrow-address instance for the end-of-memory case.
module tb_grad_bram_seq;
    localparam int unsigned AW  = 13;
    localparam int unsigned AW4 = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_i = 1'b0;
    logic          stop_i = 1'b0;
    logic          busy_i = 1'b0;
    logic [AW-1:0] end_addr_i = '0;
    logic [15:0]   interval_i = '0;
    logic [AW-1:0] bram_addr_o;
    logic          bram_en_o;
    logic [31:0]   bram_data_i = '0;
    logic [31:0]   data_o;
    logic          valid_o, running_o, done_o, stall_o;

    logic           s4_start = 1'b0;
    logic [AW4-1:0] s4_end = '0;
    logic [15:0]    s4_ivl = '0;
    logic [AW4-1:0] s4_addr;
    logic           s4_en;
    logic [31:0]    s4_rdata = '0;
    logic [31:0]    s4_data;
    logic           s4_valid, s4_running, s4_done, s4_stall;

    logic [31:0] mem  [0:63];
    logic [31:0] mem4 [0:15];
    logic [31:0] exp_q[$];
    logic [31:0] q4[$];
    int          issue_cyc[$];
    int          cyc = 0, n_checks = 0, n_errors = 0, n_valid = 0, n_done = 0;
    int          n_valid4 = 0, n_done4 = 0, fa4 = 0;

    grad_bram_seq #(.ADDR_W(AW), .GUARD(3)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .stop_i(stop_i),
        .end_addr_i(end_addr_i), .interval_i(interval_i),
        .bram_addr_o(bram_addr_o), .bram_en_o(bram_en_o), .bram_data_i(bram_data_i),
        .data_o(data_o), .valid_o(valid_o), .busy_i(busy_i),
        .running_o(running_o), .done_o(done_o), .stall_o(stall_o)
    );

    grad_bram_seq #(.ADDR_W(AW4), .GUARD(3)) dut4 (
        .clk(clk), .rst(rst), .start_i(s4_start), .stop_i(1'b0),
        .end_addr_i(s4_end), .interval_i(s4_ivl),
        .bram_addr_o(s4_addr), .bram_en_o(s4_en), .bram_data_i(s4_rdata),
        .data_o(s4_data), .valid_o(s4_valid), .busy_i(1'b0),
        .running_o(s4_running), .done_o(s4_done), .stall_o(s4_stall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle-latency BRAM models.
    always @(posedge clk) if (bram_en_o) bram_data_i <= mem[bram_addr_o[5:0]];
    always @(posedge clk) if (s4_en) s4_rdata <= mem4[s4_addr];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [31:0] w;
        if (!rst) begin
            if (valid_o) begin
                n_valid++;
                issue_cyc.push_back(cyc);
                chk("issue_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    chk("issue_data", data_o, w);
                end
            end
            if (done_o) n_done++;
            if (s4_valid) begin
                n_valid4++;
                chk("a4_issue_expected", 32'(q4.size() != 0), 32'd1);
                if (q4.size() != 0) begin
                    w = q4.pop_front();
                    chk("a4_issue_data", s4_data, w);
                end
            end
            if (s4_en) begin
                chk("a4_fetch_addr", 32'(s4_addr), 32'(fa4));
                fa4++;
            end
            if (s4_done) n_done4++;
        end
    end

    task automatic start_run(input logic [AW-1:0] end_a, input logic [15:0] ivl);
        @(negedge clk);
        end_addr_i = end_a;
        interval_i = ivl;
        start_i    = 1'b1;
        for (int i = 0; i <= int'(end_a); i++) exp_q.push_back(mem[i]);
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        int n;
        n = 0;
        while (done_o !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("done_within_budget", 32'(done_o), 32'd1);
        at = cyc;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: run did not complete at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int done_at, n, seen, fall, nv, nd;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        for (int i = 0; i < 16; i++) mem4[i] = 32'h0600_0000 | 32'(i * 3 + 1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(valid_o), 32'd0);
        chk("rst_en", 32'(bram_en_o), 32'd0);
        chk("rst_running", 32'(running_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_data", data_o, 32'd0);
        chk("rst_addr", 32'(bram_addr_o), 32'd0);
        rst = 1'b0;

        // Three words, interval 10; inputs change after start and must be ignored
        mem[0] = 32'h0000_0001; mem[1] = 32'h0200_0002; mem[2] = 32'h0500_0003;
        issue_cyc.delete();
        start_run(AW'(2), 16'd10);
        end_addr_i = '0;
        interval_i = 16'd3;
        wait_done(200, done_at);
        @(negedge clk);
        chk("ivl10_issues", 32'(issue_cyc.size()), 32'd3);
        if (issue_cyc.size() == 3) begin
            chk("ivl10_gap1", 32'(issue_cyc[1] - issue_cyc[0]), 32'd10);
            chk("ivl10_gap2", 32'(issue_cyc[2] - issue_cyc[1]), 32'd10);
            chk("ivl10_done_lat", 32'(done_at - issue_cyc[2]), 32'd1);
        end
        chk("ivl10_stall", 32'(stall_o), 32'd0);
        chk("ivl10_idle_after", 32'(running_o), 32'd0);

        // Interval 0, non-broadcast words with busy high: spacing is 4
        mem[0] = 32'h0012_3456; mem[1] = 32'h02AB_CDEF; mem[2] = 32'h0400_0001; mem[3] = 32'h06FF_FFFF;
        busy_i = 1'b1;
        issue_cyc.delete();
        start_run(AW'(3), 16'd0);
        wait_done(200, done_at);
        @(negedge clk);
        busy_i = 1'b0;
        chk("ivl0_issues", 32'(issue_cyc.size()), 32'd4);
        if (issue_cyc.size() == 4) begin
            for (int i = 1; i < 4; i++) chk("ivl0_gap", 32'(issue_cyc[i] - issue_cyc[i-1]), 32'd4);
        end
        chk("ivl0_stall", 32'(stall_o), 32'd0);

        // Two broadcasts; busy held high 50 cycles after the first
        mem[0] = 32'h0100_0100; mem[1] = 32'h0300_0200;
        issue_cyc.delete();
        start_run(AW'(1), 16'd4);
        n = 0;
        while (valid_o !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bcast_first_issue", 32'(valid_o), 32'd1);
        busy_i = 1'b1;
        repeat (50) @(negedge clk);
        busy_i = 1'b0;
        fall = cyc;
        wait_done(200, done_at);
        @(negedge clk);
        chk("bcast_issues", 32'(issue_cyc.size()), 32'd2);
        if (issue_cyc.size() == 2) chk("bcast_issue_cycle", 32'(issue_cyc[1]), 32'(fall + 1));
        chk("bcast_stall", 32'(stall_o), 32'd1);

        // Stop in HOLD of word 5
        for (int i = 0; i < 8; i++) mem[i] = 32'h0000_0100 + 32'(i);
        start_run(AW'(7), 16'd6);
        chk("stop_stall_cleared", 32'(stall_o), 32'd0);
        seen = 0;
        n = 0;
        while (seen < 5 && n < 300) begin
            @(negedge clk);
            n++;
            if (valid_o) seen++;
        end
        chk("stop_five_issued", 32'(seen), 32'd5);
        repeat (3) @(negedge clk);
        chk("stop_hold_addr", 32'(bram_addr_o), 32'd5);
        chk("stop_hold_data", data_o, mem[5]);
        nv = n_valid;
        nd = n_done;
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
        chk("stop_running", 32'(running_o), 32'd0);
        exp_q.delete();
        repeat (20) @(negedge clk);
        chk("stop_no_issue", 32'(n_valid), 32'(nv));
        chk("stop_no_done", 32'(n_done), 32'(nd));

        // start and stop together in IDLE: stays idle
        start_i = 1'b1;
        stop_i  = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        stop_i  = 1'b0;
        chk("startstop_running", 32'(running_o), 32'd0);
        chk("startstop_en", 32'(bram_en_o), 32'd0);

        // Restart from address 0; a start while running is ignored
        nv = n_valid;
        start_run(AW'(1), 16'd4);
        chk("restart_en", 32'(bram_en_o), 32'd1);
        chk("restart_addr", 32'(bram_addr_o), 32'd0);
        start_i    = 1'b1;
        end_addr_i = AW'(5);
        @(negedge clk);
        start_i = 1'b0;
        wait_done(200, done_at);
        repeat (5) @(negedge clk);
        chk("restart_issues", 32'(n_valid - nv), 32'd2);
        chk("restart_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset during WAITD with a simultaneous start
        start_run(AW'(7), 16'd4);
        @(negedge clk);
        rst     = 1'b1;
        start_i = 1'b1;
        @(negedge clk);
        chk("wrst_valid", 32'(valid_o), 32'd0);
        chk("wrst_en", 32'(bram_en_o), 32'd0);
        chk("wrst_running", 32'(running_o), 32'd0);
        chk("wrst_done", 32'(done_o), 32'd0);
        chk("wrst_stall", 32'(stall_o), 32'd0);
        chk("wrst_data", data_o, 32'd0);
        chk("wrst_addr", 32'(bram_addr_o), 32'd0);
        rst     = 1'b0;
        start_i = 1'b0;
        exp_q.delete();
        nv = n_valid;
        repeat (10) @(negedge clk);
        chk("wrst_stays_idle", 32'(running_o), 32'd0);
        chk("wrst_no_issue", 32'(n_valid), 32'(nv));

        // 4-bit address instance playing all 16 words
        @(negedge clk);
        s4_end   = 4'hF;
        s4_ivl   = 16'd0;
        s4_start = 1'b1;
        for (int i = 0; i < 16; i++) q4.push_back(mem4[i]);
        @(negedge clk);
        s4_start = 1'b0;
        n = 0;
        while (s4_done !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("a4_done_within_budget", 32'(s4_done), 32'd1);
        repeat (10) @(negedge clk);
        chk("a4_issues", 32'(n_valid4), 32'd16);
        chk("a4_done_count", 32'(n_done4), 32'd1);
        chk("a4_fetches", 32'(fa4), 32'd16);
        chk("a4_running", 32'(s4_running), 32'd0);
        chk("a4_stall", 32'(s4_stall), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
